// File: rtl/combat_resolver_v2.sv
// Two-player combat arbiter: hitbox/hurtbox hits, damage, hitstun, knockback, round FSM.
// Optional macro GUARD_EN enables guarding (chip damage, halved knockback, no stun).
module combat_resolver_v2 #(
    parameter int POS_WIDTH      = 10,
    parameter int HEALTH_WIDTH   = 8,
    parameter int HEALTH_MAX     = 100,
    parameter int HURT_W         = 16,
    parameter int HURT_H         = 28,
    parameter int HURT_OFFX      = -8,
    parameter int HURT_OFFY      = -28,
    parameter int ATK1_W         = 18,
    parameter int ATK1_H         = 12,
    parameter int ATK1_FWD       = 14,
    parameter int ATK1_UP        = -16,
    parameter int ATK2_W         = 22,
    parameter int ATK2_H         = 14,
    parameter int ATK2_FWD       = 20,
    parameter int ATK2_UP        = -12,
    parameter int ATK1_ACT_START = 3,
    parameter int ATK1_ACT_END   = 6,
    parameter int ATK2_ACT_START = 5,
    parameter int ATK2_ACT_END   = 9,
    parameter int DMG_LIGHT      = 8,
    parameter int DMG_HEAVY      = 15,
    parameter int HITSTUN_LIGHT  = 12,
    parameter int HITSTUN_HEAVY  = 20,
    parameter int KB_LIGHT_X     = 3,
    parameter int KB_LIGHT_Y     = -2,
    parameter int KB_HEAVY_X     = 5,
    parameter int KB_HEAVY_Y     = -3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    SCEN,
    input  logic                    round_start,
    input  logic [POS_WIDTH-1:0]    p1_x,
    input  logic [POS_WIDTH-1:0]    p1_y,
    input  logic                    p1_face_right,
    input  logic                    p1_attack_active,
    input  logic [1:0]              p1_attack_type,
    input  logic [5:0]              p1_attack_frame,
    input  logic                    p1_guard,
    input  logic [POS_WIDTH-1:0]    p2_x,
    input  logic [POS_WIDTH-1:0]    p2_y,
    input  logic                    p2_face_right,
    input  logic                    p2_attack_active,
    input  logic [1:0]              p2_attack_type,
    input  logic [5:0]              p2_attack_frame,
    input  logic                    p2_guard,
    output logic                    p1_hit_event,
    output logic                    p1_hitstun_active,
    output logic signed [7:0]       p1_kb_dx,
    output logic signed [7:0]       p1_kb_dy,
    output logic [HEALTH_WIDTH-1:0] p1_health,
    output logic                    p2_hit_event,
    output logic                    p2_hitstun_active,
    output logic signed [7:0]       p2_kb_dx,
    output logic signed [7:0]       p2_kb_dy,
    output logic [HEALTH_WIDTH-1:0] p2_health,
    output logic [1:0]              round_state,
    output logic [1:0]              winner
);

    localparam int CW = POS_WIDTH + 2;
    typedef logic signed [CW-1:0] crd_t;
    typedef logic signed [7:0] kb_t;
    typedef logic [HEALTH_WIDTH-1:0] hp_t;
    typedef enum logic [1:0] {IDLE = 2'd0, FIGHT = 2'd1, KO = 2'd2} state_t;

    function automatic logic lands(input crd_t ax, input crd_t ay, input logic af,
                                   input logic [1:0] at, input logic [5:0] fr,
                                   input crd_t dx, input crd_t dy);
        crd_t w, h, fwd, up, bx, by, hx, hy;
        logic win;
        w = '0;
        h = '0;
        fwd = '0;
        up = '0;
        win = 1'b0;
        unique case (1'b1)
            (at == 2'd1): begin
                w   = crd_t'(ATK1_W);
                h   = crd_t'(ATK1_H);
                fwd = crd_t'(ATK1_FWD);
                up  = crd_t'(ATK1_UP);
                win = fr >= 6'(ATK1_ACT_START) && fr <= 6'(ATK1_ACT_END);
            end
            (at == 2'd2): begin
                w   = crd_t'(ATK2_W);
                h   = crd_t'(ATK2_H);
                fwd = crd_t'(ATK2_FWD);
                up  = crd_t'(ATK2_UP);
                win = fr >= 6'(ATK2_ACT_START) && fr <= 6'(ATK2_ACT_END);
            end
            default: ;
        endcase
        bx = af ? ax + fwd : ax - (fwd + w);
        by = ay + up;
        hx = dx + crd_t'(HURT_OFFX);
        hy = dy + crd_t'(HURT_OFFY);
        return win && (bx < hx + crd_t'(HURT_W)) && (hx < bx + w)
                   && (by < hy + crd_t'(HURT_H)) && (hy < by + h);
    endfunction

    crd_t       px[2], py[2];
    logic       face[2], act[2], grd[2];
    logic [1:0] typ[2];
    logic [5:0] frm[2];

    assign px[0] = {2'b00, p1_x};
    assign py[0] = {2'b00, p1_y};
    assign px[1] = {2'b00, p2_x};
    assign py[1] = {2'b00, p2_y};
    assign face[0] = p1_face_right;
    assign face[1] = p2_face_right;
    assign act[0] = p1_attack_active;
    assign act[1] = p2_attack_active;
    assign grd[0] = p1_guard;
    assign grd[1] = p2_guard;
    assign typ[0] = p1_attack_type;
    assign typ[1] = p2_attack_type;
    assign frm[0] = p1_attack_frame;
    assign frm[1] = p2_attack_frame;

    state_t     state_q, state_d;
    logic       start;
    logic [1:0] win_q;
    hp_t        hp[2];
    logic       stun[2], hev[2], conn[2];
    logic [7:0] cnt[2];
    kb_t        kbx[2], kby[2];

    // Per-defender view: index d is hit by player 1-d.
    logic       hit[2], blk[2];
    hp_t        amt[2];
    logic [7:0] hs[2];
    kb_t        kfx[2], kfy[2];

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            hit[d] = (state_q == FIGHT) && act[1-d] && !conn[1-d]
                     && lands(px[1-d], py[1-d], face[1-d], typ[1-d], frm[1-d], px[d], py[d]);
            amt[d] = (typ[1-d] == 2'd2) ? hp_t'(DMG_HEAVY) : hp_t'(DMG_LIGHT);
            hs[d]  = (typ[1-d] == 2'd2) ? 8'(HITSTUN_HEAVY - 1) : 8'(HITSTUN_LIGHT - 1);
            kfx[d] = (typ[1-d] == 2'd2) ? kb_t'(KB_HEAVY_X) : kb_t'(KB_LIGHT_X);
            kfy[d] = (typ[1-d] == 2'd2) ? kb_t'(KB_HEAVY_Y) : kb_t'(KB_LIGHT_Y);
            if (!face[1-d]) kfx[d] = -kfx[d];
`ifdef GUARD_EN
            blk[d] = grd[d] && (face[d] == (px[1-d] >= px[d]));
`else
            blk[d] = 1'b0 & grd[d];
`endif
            if (blk[d]) amt[d] = amt[d] >> 2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else if (SCEN) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start = 1'b0;
        unique case (state_q)
            IDLE, KO: begin
                if (round_start) begin
                    state_d = FIGHT;
                    start = 1'b1;
                end
            end
            FIGHT: if (hp[0] == '0 || hp[1] == '0) state_d = KO;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
            for (int i = 0; i < 2; i++) begin
                hp[i]   <= hp_t'(HEALTH_MAX);
                stun[i] <= 1'b0;
                hev[i]  <= 1'b0;
                conn[i] <= 1'b0;
                cnt[i]  <= '0;
                kbx[i]  <= '0;
                kby[i]  <= '0;
            end
        end else if (SCEN) begin
            if (start) win_q <= '0;
            else if (state_q == FIGHT && (hp[0] == '0 || hp[1] == '0))
                win_q <= {hp[0] == '0, hp[1] == '0};
            for (int i = 0; i < 2; i++) begin
                if (start) begin
                    hp[i]   <= hp_t'(HEALTH_MAX);
                    stun[i] <= 1'b0;
                    hev[i]  <= 1'b0;
                    conn[i] <= 1'b0;
                    cnt[i]  <= '0;
                    kbx[i]  <= '0;
                    kby[i]  <= '0;
                end else begin
                    hev[i] <= hit[i] && !blk[i];
                    if (!act[i]) conn[i] <= 1'b0;
                    else if (hit[1-i]) conn[i] <= 1'b1;
                    if (hit[i]) hp[i] <= (hp[i] > amt[i]) ? hp[i] - amt[i] : '0;
                    if (hit[i] && !blk[i]) begin
                        stun[i] <= 1'b1;
                        cnt[i]  <= hs[i];
                        kbx[i]  <= kfx[i];
                        kby[i]  <= kfy[i];
                    end else begin
                        if (cnt[i] == '0) begin
                            stun[i] <= 1'b0;
                            kbx[i]  <= '0;
                            kby[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] - 8'd1;
                        end
                        // A guarded hit pushes back without touching the stun timer.
                        if (hit[i]) begin
                            kbx[i] <= kfx[i] >>> 1;
                            kby[i] <= '0;
                        end
                    end
                end
            end
        end
    end

    assign p1_hit_event      = hev[0];
    assign p1_hitstun_active = stun[0];
    assign p1_kb_dx          = kbx[0];
    assign p1_kb_dy          = kby[0];
    assign p1_health         = hp[0];
    assign p2_hit_event      = hev[1];
    assign p2_hitstun_active = stun[1];
    assign p2_kb_dx          = kbx[1];
    assign p2_kb_dy          = kby[1];
    assign p2_health         = hp[1];
    assign round_state       = state_q;
    assign winner            = win_q;

endmodule

// File: tb/tb_combat_resolver_v2.sv
// Scoreboard bench for combat_resolver_v2: directed frames push expected
// output snapshots; a monitor compares them after the matching clock edge.
module tb_combat_resolver_v2;

    typedef struct packed {
        logic [1:0] rs;
        logic [1:0] win;
        logic       e1;
        logic       s1;
        logic [7:0] h1;
        logic [7:0] kx1;
        logic [7:0] ky1;
        logic       e2;
        logic       s2;
        logic [7:0] h2;
        logic [7:0] kx2;
        logic [7:0] ky2;
    } snap_t;

    typedef struct {
        int    due;
        string nm;
        snap_t s;
    } item_t;

    logic clk = 1'b0;
    logic reset, scen, round_start;
    logic [9:0] x1, y1, x2, y2;
    logic f1, f2, a1, a2, g1, g2;
    logic [1:0] t1, t2;
    logic [5:0] fr1, fr2;
    logic e1o, s1o, e2o, s2o;
    logic signed [7:0] kx1o, ky1o, kx2o, ky2o;
    logic [7:0] h1o, h2o;
    logic [1:0] rso, wino;

    item_t q[$];
    snap_t e;
    int cyc = 0;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    combat_resolver_v2 dut (
        .clk(clk), .reset(reset), .SCEN(scen), .round_start(round_start),
        .p1_x(x1), .p1_y(y1), .p1_face_right(f1), .p1_attack_active(a1),
        .p1_attack_type(t1), .p1_attack_frame(fr1), .p1_guard(g1),
        .p2_x(x2), .p2_y(y2), .p2_face_right(f2), .p2_attack_active(a2),
        .p2_attack_type(t2), .p2_attack_frame(fr2), .p2_guard(g2),
        .p1_hit_event(e1o), .p1_hitstun_active(s1o), .p1_kb_dx(kx1o),
        .p1_kb_dy(ky1o), .p1_health(h1o),
        .p2_hit_event(e2o), .p2_hitstun_active(s2o), .p2_kb_dx(kx2o),
        .p2_kb_dy(ky2o), .p2_health(h2o),
        .round_state(rso), .winner(wino)
    );

    initial begin
        item_t it;
        snap_t o;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                it = q.pop_front();
                total++;
                o = '{rso, wino, e1o, s1o, h1o, kx1o, ky1o, e2o, s2o, h2o, kx2o, ky2o};
                if (it.due != cyc)
                    $display("FAIL %s: missed check at cycle %0d (now %0d)", it.nm, it.due, cyc);
                else if (o !== it.s)
                    $display("FAIL %s: got %h want %h", it.nm, o, it.s);
                else
                    passed++;
            end
        end
    end

    task automatic step(input logic sc, input logic rst, input logic st,
                        input string nm, input bit chk);
        scen = sc;
        reset = rst;
        round_start = st;
        if (chk) q.push_back('{cyc + 1, nm, e});
        @(negedge clk);
    endtask

    task automatic trade(input logic [1:0] t, input logic [5:0] f);
        a1 = 1'b1; a2 = 1'b1;
        t1 = t; t2 = t;
        fr1 = f; fr2 = f;
        step(1, 0, 0, "trade", 0);
        a1 = 1'b0; a2 = 1'b0;
        step(1, 0, 0, "trade_rel", 0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish, total %0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; scen = 1'b0; round_start = 1'b0;
        x1 = 10'd100; y1 = 10'd200; f1 = 1'b1;
        x2 = 10'd120; y2 = 10'd200; f2 = 1'b0;
        a1 = 1'b0; a2 = 1'b0; t1 = 2'd0; t2 = 2'd0;
        fr1 = 6'd0; fr2 = 6'd0; g1 = 1'b0; g2 = 1'b0;
        @(negedge clk);

        e = '0; e.h1 = 8'd100; e.h2 = 8'd100;
        step(0, 1, 0, "reset", 1);
        e.rs = 2'd1;
        step(1, 0, 1, "start", 1);

        // single light hit, held attack, stun length
        a1 = 1'b1; t1 = 2'd1; fr1 = 6'd4;
        e.e2 = 1'b1; e.h2 = 8'd92; e.s2 = 1'b1; e.kx2 = 8'd3; e.ky2 = 8'hFE;
        step(1, 0, 0, "light_hit", 1);
        step(0, 0, 0, "hold_no_scen", 1);
        fr1 = 6'd6; e.e2 = 1'b0;
        for (int k = 1; k <= 11; k++) step(1, 0, 0, "stun_on", 1);
        e.s2 = 1'b0; e.kx2 = 8'd0; e.ky2 = 8'd0;
        step(1, 0, 0, "stun_off", 1);
        a1 = 1'b0;
        step(1, 0, 0, "release", 1);
        a1 = 1'b1; fr1 = 6'd3;
        e.e2 = 1'b1; e.h2 = 8'd84; e.s2 = 1'b1; e.kx2 = 8'd3; e.ky2 = 8'hFE;
        step(1, 0, 0, "second_hit", 1);
        a1 = 1'b0; e.e2 = 1'b0;
        repeat (11) step(1, 0, 0, "", 0);
        e.s2 = 1'b0; e.kx2 = 8'd0; e.ky2 = 8'd0;
        step(1, 0, 0, "stun_end2", 1);

        // active window and edge-touching boundaries
        a1 = 1'b1; fr1 = 6'd2;
        step(1, 0, 0, "frame2_nohit", 1);
        fr1 = 6'd7;
        step(1, 0, 0, "frame7_nohit", 1);
        x2 = 10'd140; fr1 = 6'd4;
        step(1, 0, 0, "touch_nohit", 1);
        x2 = 10'd139;
        e.e2 = 1'b1; e.h2 = 8'd76; e.s2 = 1'b1; e.kx2 = 8'd3; e.ky2 = 8'hFE;
        step(1, 0, 0, "overlap1_hit", 1);
        a1 = 1'b0; x2 = 10'd120;
        step(1, 0, 0, "", 0);

        // reset during stun, then a fresh round
        e = '0; e.h1 = 8'd100; e.h2 = 8'd100;
        step(0, 1, 0, "reset_mid", 1);
        e.rs = 2'd1;
        step(1, 0, 1, "restart", 1);

        // trades down to 15 each, then a double KO
        repeat (5) trade(2'd1, 6'd4);
        repeat (3) trade(2'd2, 6'd5);
        e.h1 = 8'd15; e.h2 = 8'd15; e.s1 = 1'b1; e.s2 = 1'b1;
        e.kx1 = 8'hFB; e.ky1 = 8'hFD; e.kx2 = 8'h05; e.ky2 = 8'hFD;
        step(1, 0, 0, "pre_ko", 1);
        a1 = 1'b1; a2 = 1'b1; t1 = 2'd2; t2 = 2'd2; fr1 = 6'd5; fr2 = 6'd5;
        e.e1 = 1'b1; e.e2 = 1'b1; e.h1 = 8'd0; e.h2 = 8'd0;
        step(1, 0, 0, "double_hit", 1);
        a1 = 1'b0; a2 = 1'b0;
        e.e1 = 1'b0; e.e2 = 1'b0; e.rs = 2'd2; e.win = 2'd3;
        step(1, 0, 0, "ko_draw", 1);
        a1 = 1'b1; a2 = 1'b1; fr1 = 6'd6; fr2 = 6'd6;
        step(1, 0, 0, "ko_nohit", 1);
        e = '0; e.h1 = 8'd100; e.h2 = 8'd100; e.rs = 2'd1;
        step(1, 0, 1, "ko_restart", 1);
        a1 = 1'b0; a2 = 1'b0;
        step(1, 0, 0, "", 0);

        // heavy re-hit reloads stun mid-countdown
        a1 = 1'b1; t1 = 2'd1; fr1 = 6'd4;
        e.e2 = 1'b1; e.h2 = 8'd92; e.s2 = 1'b1; e.kx2 = 8'd3; e.ky2 = 8'hFE;
        step(1, 0, 0, "c_light", 1);
        a1 = 1'b0; e.e2 = 1'b0;
        repeat (5) step(1, 0, 0, "", 0);
        step(1, 0, 0, "cnt5", 1);
        a1 = 1'b1; t1 = 2'd2; fr1 = 6'd5;
        e.e2 = 1'b1; e.h2 = 8'd77; e.kx2 = 8'd5; e.ky2 = 8'hFD;
        step(1, 0, 0, "rehit_heavy", 1);
        a1 = 1'b0; e.e2 = 1'b0;
        for (int k = 1; k <= 19; k++) step(1, 0, 0, "heavy_stun_last", k == 19);
        e.s2 = 1'b0; e.kx2 = 8'd0; e.ky2 = 8'd0;
        step(1, 0, 0, "heavy_stun_off", 1);
        a1 = 1'b1; t1 = 2'd1; fr1 = 6'd4;
        e.e2 = 1'b1; e.h2 = 8'd69; e.s2 = 1'b1; e.kx2 = 8'd3; e.ky2 = 8'hFE;
        step(1, 0, 0, "c_light2", 1);
        e = '0; e.h1 = 8'd100; e.h2 = 8'd100;
        step(0, 1, 0, "reset_stun", 1);
        step(1, 0, 0, "idle_nohit", 1);

        scen = 1'b0;
        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            total++;
            $display("FAIL %s: never checked (due %0d)", it.nm, it.due);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/combat_resolver_v2.md
Name: combat_resolver_v2

Overview:
- Second-generation two-player combat arbiter. Sits between the two player_state/physics blocks and the HUD.
- Detects attack-hitbox vs hurtbox overlaps inside a per-attack active-frame window, with each attack instance connecting at most once.
- Applies parametrised damage to saturating health registers, drives hitstun and knockback, and runs a round FSM (IDLE/FIGHT/KO) that reports the winner or a draw.
- All game-state updates advance only on SCEN (frame-enable) cycles.

Parameters:
- POS_WIDTH, 10, unsigned position width.
- HEALTH_WIDTH, 8, health register width.
- HEALTH_MAX, 100, health loaded at round start (must fit HEALTH_WIDTH).
- HURT_W / HURT_H / HURT_OFFX / HURT_OFFY, 16 / 28 / -8 / -28, hurtbox size and top-left offset from feet position.
- ATK1_W / ATK1_H / ATK1_FWD / ATK1_UP, 18 / 12 / 14 / -16, light hitbox geometry.
- ATK2_W / ATK2_H / ATK2_FWD / ATK2_UP, 22 / 14 / 20 / -12, heavy hitbox geometry.
- ATK1_ACT_START / ATK1_ACT_END, 3 / 6, light active frames (inclusive).
- ATK2_ACT_START / ATK2_ACT_END, 5 / 9, heavy active frames (inclusive).
- DMG_LIGHT / DMG_HEAVY, 8 / 15, damage per hit.
- HITSTUN_LIGHT / HITSTUN_HEAVY, 12 / 20, hitstun length in SCEN frames (≥1).
- KB_LIGHT_X / KB_LIGHT_Y / KB_HEAVY_X / KB_HEAVY_Y, 3 / -2 / 5 / -3, knockback magnitudes.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- SCEN, in, 1, frame enable; state advances only when high.
- round_start, in, 1, sampled on SCEN; starts a round from IDLE or KO.
- pN_x, pN_y, in, POS_WIDTH, feet position (N=1,2).
- pN_face_right, in, 1, facing.
- pN_attack_active, in, 1, attack in progress.
- pN_attack_type, in, 2, 0 none, 1 light, 2 heavy, 3 treated as none.
- pN_attack_frame, in, 6, frame index within the attack.
- pN_guard, in, 1, guard held (used only with GUARD_EN).
- pN_hit_event, out, 1, one-SCEN-cycle pulse when pN is hit.
- pN_hitstun_active, out, 1, pN is stunned.
- pN_kb_dx, pN_kb_dy, out, 8 signed, knockback applied to pN.
- pN_health, out, HEALTH_WIDTH, current health.
- round_state, out, 2, 0 IDLE, 1 FIGHT, 2 KO.
- winner, out, 2, 0 none, 1 P1, 2 P2, 3 draw.

Behaviour:
- Reset (synchronous, clk edge, independent of SCEN): round_state=IDLE, winner=0, health=HEALTH_MAX, all events/stun/kb/counters/latches=0. Reset mid-round aborts the round immediately.
- Geometry: signed arithmetic at POS_WIDTH+2 bits.
  - Hurtbox top-left = (x+HURT_OFFX, y+HURT_OFFY).
  - Hitbox x = x+FWD when facing right, else x-(FWD+W); hitbox y = y+UP.
  - Overlap is strict: ax<bx+bw && bx<ax+aw, same test on y. Touching edges do not hit.
- Hit condition for attacker A on defender D, all required:
  - round_state==FIGHT
  - A attack_active, with type 1 or 2
  - attack_frame within [ACT_START, ACT_END] for that type
  - boxes overlap
  - A's connected latch is clear
- Connected latch: set on the SCEN cycle A lands a hit. Cleared on any SCEN cycle where A attack_active==0. A single attack instance therefore damages at most once.
- On a hit, on the same SCEN edge:
  - D hit_event=1.
  - D health -= DMG, saturating at 0.
  - D hitstun_active=1 and stun_cnt=HITSTUN-1 (reloads any stun in progress).
  - D kb_dx = +KB_X if A faces right, else -KB_X; D kb_dy = KB_Y.
- hit_event is cleared on every other SCEN cycle. Outputs hold when SCEN is low.
- Stun countdown, each SCEN cycle with no new hit: if cnt==0, hitstun_active=0 and kb=0; else cnt-1. Hitstun is high for exactly HITSTUN SCEN cycles. A new hit overrides the countdown.
- Trades: both hits can resolve on the same cycle, each independently.
- Round FSM:
  - IDLE -> FIGHT on round_start: health reloaded, winner=0, stun/kb/latches cleared.
  - FIGHT -> KO on the cycle after any health reaches 0. winner = 1 if only P2 is at 0, 2 if only P1 is at 0, 3 if both.
  - KO -> FIGHT on round_start, with the same reloads.
  - round_start in FIGHT is ignored.
  - In IDLE/KO no hits resolve; stun still counts down to 0.

Optional Feature:
- Macro GUARD_EN.
- Defined: a defender with guard=1 that faces the attacker (faces right iff attacker x ≥ defender x) takes chip damage DMG>>2 (saturating). No hitstun, no hit_event, kb_dx halved (arithmetic shift), kb_dy=0. The attacker's connected latch is still set.
- Undefined: guard ports exist but are ignored; every hit is a full hit.

Test Plan:
- Reset, round_start, P1 at (100,200) facing right, P2 at (120,200), P1 light at frame 4 -> P2 hit_event one pulse, P2 health 92, hitstun high 12 SCEN cycles, kb_dx=+3, kb_dy=-2.
- Same setup, attack held frames 3..6 -> exactly one hit. Release, then second attack -> health 84.
- Light attack at frame 2 and frame 7 with overlap -> no hit. Hitbox edge exactly touching hurtbox edge -> no hit.
- Simultaneous heavy hits with both players at health 15 -> both health 0, next SCEN round_state=KO, winner=3. round_start -> FIGHT, health 100, winner 0.
- P2 in hitstun (cnt 5), re-hit by heavy -> stun reloads to 20 frames, health drops 15. Reset asserted mid-stun -> all outputs at reset values on next clk.
- GUARD_EN: P2 guard=1 facing P1, P1 heavy hit -> health 97, no hit_event, hitstun 0, kb_dx=+2, kb_dy=0. P2 facing away -> full hit.
